reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Eight-entry circular reorder buffer for the Tomasulo core. The issue stage writes entries in program order. The common data bus (CDB) marks entries complete out of order. This block reads the head and retires completed entries in order to the register bank through a registered commit port. It also exposes a combinational operand-lookup port so issue can take values that have completed but not yet committed.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two)
- TAG_W, 3, entry tag width, log2(DEPTH)
- REG_W, 4, architectural register index width (16 registers)
- DATA_W, 16, result data width

Ports:
- clk1  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  issue requests a new entry this cycle
- alloc_dest  in  REG_W  destination register of the issued instruction
- alloc_ready  out  1  buffer not full; allocation accepted when alloc_valid && alloc_ready
- alloc_tag  out  TAG_W  tag the next allocation will receive (equals tail pointer)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  tag being completed
- cdb_data  in  DATA_W  result value
- rd_tag  in  TAG_W  operand lookup tag
- rd_ready  out  1  entry rd_tag is valid and done (combinational)
- rd_data  out  DATA_W  value of entry rd_tag (combinational)
- flush  in  1  discard all entries
- commit_valid  out  1  registered; high for one cycle per retired entry
- commit_dest  out  REG_W  register bank index to write
- commit_data  out  DATA_W  value to write
- commit_tag  out  TAG_W  tag of the retired entry
- count  out  TAG_W+1  occupied entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Per-entry state: valid, done, dest, data. Pointers: head_p, tail_p (TAG_W bits, wrap modulo DEPTH). count is held as a separate register.
- Allocate: when alloc_valid && !full, write entry[tail_p] with valid=1, done=0 and dest=alloc_dest, then increment tail_p.
  - alloc_valid while full: ignored, no state change.
- Writeback: when cdb_valid and entry[cdb_tag].valid, set done=1 and data=cdb_data.
  - CDB to an invalid entry: ignored.
  - CDB to an already-done entry: overwrites data. Issue must not do this.
- Commit: when entry[head_p].valid && done, retire it at the clock edge.
  - Clear valid; increment head_p.
  - Register commit_valid=1 with that entry's dest, data and tag.
  - Otherwise commit_valid=0. The other commit outputs hold their last values.
  - At most one commit per cycle. The register bank always accepts, so there is no backpressure.
- count_next = count + alloc_accepted − committed. Allocation and commit in the same cycle leave count unchanged.
- full/empty/alloc_ready are derived from registered count only. A commit in the same cycle does not free a slot for an allocation in that cycle.
- rd_ready = entry[rd_tag].valid && done. rd_data = entry[rd_tag].data. No same-cycle CDB bypass.
- Flush (synchronous, highest priority):
  - Clear all valid bits.
  - head_p = tail_p = 0, count = 0.
  - No commit that cycle (commit_valid=0), even if the head was done.
  - Allocation and CDB inputs are ignored that cycle.

## Timing
- Reset: all entries invalid, head_p = tail_p = 0, count=0.
  - commit_valid=0, commit_dest/commit_data/commit_tag=0.
  - empty=1, full=0, alloc_ready=1, alloc_tag=0.
  - Reset asserted mid-operation clears everything immediately, with no commit pulse.
- Allocation at edge N: entry visible to rd_* after edge N; alloc_tag advances after edge N.
- CDB at edge M: done visible on rd_ready after edge M. If the entry is at the head, it commits at edge M+1, and commit_valid is high in the cycle after edge M+1.
- Back-to-back completed entries commit on consecutive edges: one per cycle, in tag order.
- An entry completed while not at the head waits until all older entries commit.
- Wrap-around: tail_p 7→0 and head_p 7→0 with no gap. full when count=8 and head_p == tail_p.

## Test plan
- Reset, then three allocations with dest 5, 6, 7 → tags 0, 1, 2; count=3; empty=0.
- Out-of-order completion: CDB tag1=0x22, then tag0=0x11 → commits tag0 (dest 5, 0x11), then tag1 (dest 6, 0x22) on consecutive cycles. Before tag0 completes: no commit; rd_tag=1 gives rd_ready=1, rd_data=0x22.
- Fill 8 entries → full=1, alloc_ready=0. A ninth alloc_valid is ignored (count stays 8).
  - Then complete the head and hold alloc_valid in the same cycle → commit occurs, no allocation that cycle; the allocation succeeds next cycle and gets tag 0 (wrap).
- Stream 20 allocate/complete pairs through → tags wrap 7→0. commit_tag sequence is 0..7,0..7,0..3, with matching dest/data.
- Four entries, head done, flush asserted → no commit_valid; count=0, empty=1, alloc_tag=0. The next allocation receives tag 0.
- Assert rst asynchronously between edges with 3 entries pending → outputs at reset values immediately; no commit afterwards.

Source files
------------

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Eight-entry circular reorder buffer. Issue allocates entries in program order
// at the tail. The CDB marks entries done out of order. Completed entries retire
// in order from the head through a registered commit port.
//
// Ports:
//   clk1, rst                         clock, asynchronous active-high reset
//   alloc_valid/alloc_dest            allocation request and destination register
//   alloc_ready/alloc_tag             not full / tag the next allocation receives
//   cdb_valid/cdb_tag/cdb_data        result broadcast
//   rd_tag -> rd_ready/rd_data        combinational operand lookup
//   flush                             synchronous discard of all entries
//   commit_valid/dest/data/tag        registered retirement port
//   count/empty/full                  occupancy, from the registered count
// -----------------------------------------------------------------------------
module reorder_buffer #(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = 3,
   parameter int REG_W  = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_dest,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic [TAG_W-1:0]  rd_tag,
   output logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   input  logic              flush,
   output logic              commit_valid,
   output logic [REG_W-1:0]  commit_dest,
   output logic [DATA_W-1:0] commit_data,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [TAG_W:0]    count,
   output logic              empty,
   output logic              full
);

   localparam logic [TAG_W:0] FULL_CNT = DEPTH[TAG_W:0];

   logic              valid_q [DEPTH];
   logic              valid_d [DEPTH];
   logic              done_q  [DEPTH];
   logic              done_d  [DEPTH];
   logic [REG_W-1:0]  dest_q  [DEPTH];
   logic [REG_W-1:0]  dest_d  [DEPTH];
   logic [DATA_W-1:0] data_q  [DEPTH];
   logic [DATA_W-1:0] data_d  [DEPTH];

   logic [TAG_W-1:0]  head_q, head_d;
   logic [TAG_W-1:0]  tail_q, tail_d;
   logic [TAG_W:0]    count_q, count_d;

   logic              cvalid_q, cvalid_d;
   logic [REG_W-1:0]  cdest_q, cdest_d;
   logic [DATA_W-1:0] cdata_q, cdata_d;
   logic [TAG_W-1:0]  ctag_q, ctag_d;

   logic              full_s;
   logic              alloc_acc_s;
   logic              commit_s;
   logic              cdb_wr_s;

   // Occupancy flags come only from the registered count, so a same-cycle
   // commit never frees a slot for a same-cycle allocation.
   assign full_s      = (count_q == FULL_CNT);
   assign full        = full_s;
   assign empty       = (count_q == '0);
   assign alloc_ready = !full_s;
   assign alloc_tag   = tail_q;
   assign count       = count_q;

   // Operand lookup reads registered state only; no same-cycle CDB bypass.
   assign rd_ready = valid_q[rd_tag] && done_q[rd_tag];
   assign rd_data  = data_q[rd_tag];

   assign commit_valid = cvalid_q;
   assign commit_dest  = cdest_q;
   assign commit_data  = cdata_q;
   assign commit_tag   = ctag_q;

   // Event qualification: flush suppresses allocation, writeback and commit.
   always_comb begin
      alloc_acc_s = alloc_valid && !full_s && !flush;
      commit_s    = valid_q[head_q] && done_q[head_q] && !flush;
      cdb_wr_s    = cdb_valid && valid_q[cdb_tag] && !flush;
   end

   // Per-entry next state. Allocation never targets a valid slot, and a commit
   // at head never coincides with allocation at the same index (that would need
   // the buffer to be both full and allocating).
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      dest_d  = dest_q;
      data_d  = data_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (flush) begin
            valid_d[i] = 1'b0;
         end else begin
            if (commit_s && (head_q == TAG_W'(i))) begin
               valid_d[i] = 1'b0;
            end else begin
               valid_d[i] = valid_q[i];
            end
            if (alloc_acc_s && (tail_q == TAG_W'(i))) begin
               valid_d[i] = 1'b1;
               done_d[i]  = 1'b0;
               dest_d[i]  = alloc_dest;
            end else begin
               dest_d[i]  = dest_q[i];
            end
            if (cdb_wr_s && (cdb_tag == TAG_W'(i))) begin
               done_d[i] = 1'b1;
               data_d[i] = cdb_data;
            end else begin
               data_d[i] = data_q[i];
            end
         end
      end
   end

   // Pointers, count and the commit port next state.
   always_comb begin
      cvalid_d = commit_s;
      cdest_d  = cdest_q;
      cdata_d  = cdata_q;
      ctag_d   = ctag_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + {{(TAG_W-1){1'b0}}, commit_s};
         tail_d  = tail_q + {{(TAG_W-1){1'b0}}, alloc_acc_s};
         count_d = count_q + {{TAG_W{1'b0}}, alloc_acc_s}
                           - {{TAG_W{1'b0}}, commit_s};
      end
      if (commit_s) begin
         cdest_d = dest_q[head_q];
         cdata_d = data_q[head_q];
         ctag_d  = head_q;
      end else begin
         cdest_d = cdest_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            done_q[i]  <= 1'b0;
            dest_q[i]  <= '0;
            data_q[i]  <= '0;
         end
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         cvalid_q <= 1'b0;
         cdest_q  <= '0;
         cdata_q  <= '0;
         ctag_q   <= '0;
      end else begin
         valid_q  <= valid_d;
         done_q   <= done_d;
         dest_q   <= dest_d;
         data_q   <= data_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         cvalid_q <= cvalid_d;
         cdest_q  <= cdest_d;
         cdata_q  <= cdata_d;
         ctag_q   <= ctag_d;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Directed stimulus with hand-computed expectations. Expected commits are queued
// by the stimulus; a monitor pops and compares on every commit_valid pulse.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

   logic        clk1 = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic [3:0]  alloc_dest;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic [2:0]  rd_tag;
   logic        rd_ready;
   logic [15:0] rd_data;
   logic        flush;
   logic        commit_valid;
   logic [3:0]  commit_dest;
   logic [15:0] commit_data;
   logic [2:0]  commit_tag;
   logic [3:0]  count;
   logic        empty;
   logic        full;

   typedef struct packed {
      logic [2:0]  tag;
      logic [3:0]  dest;
      logic [15:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   reorder_buffer #(.DEPTH(8), .TAG_W(3), .REG_W(4), .DATA_W(16)) dut (
      .clk1(clk1), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_data(rd_data),
      .flush(flush),
      .commit_valid(commit_valid), .commit_dest(commit_dest),
      .commit_data(commit_data), .commit_tag(commit_tag),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic push(input logic [2:0] t, input logic [3:0] d, input logic [15:0] v);
      exp_t e;
      e.tag = t; e.dest = d; e.data = v;
      exp_q.push_back(e);
   endtask

   // Monitor: every commit pulse must match the oldest queued expectation.
   always @(negedge clk1) begin
      if (commit_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit actual_tag=%0h required=none at %0t", commit_tag, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("commit_tag",  {29'd0, commit_tag},  {29'd0, e.tag});
            chk("commit_dest", {28'd0, commit_dest}, {28'd0, e.dest});
            chk("commit_data", {16'd0, commit_data}, {16'd0, e.data});
         end
      end
   end

   task automatic chk_reset_outputs(input string tagname);
      chk({tagname, "_commit_valid"}, {31'd0, commit_valid}, 32'd0);
      chk({tagname, "_commit_dest"},  {28'd0, commit_dest},  32'd0);
      chk({tagname, "_commit_data"},  {16'd0, commit_data},  32'd0);
      chk({tagname, "_commit_tag"},   {29'd0, commit_tag},   32'd0);
      chk({tagname, "_count"},        {28'd0, count},        32'd0);
      chk({tagname, "_empty"},        {31'd0, empty},        32'd1);
      chk({tagname, "_full"},         {31'd0, full},         32'd0);
      chk({tagname, "_alloc_ready"},  {31'd0, alloc_ready},  32'd1);
      chk({tagname, "_alloc_tag"},    {29'd0, alloc_tag},    32'd0);
   endtask

   initial begin
      rst = 1'b1; alloc_valid = 1'b0; alloc_dest = 4'd0;
      cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 16'd0;
      rd_tag = 3'd0; flush = 1'b0;
      #2;
      chk_reset_outputs("reset");
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Three allocations, dest 5,6,7 -> tags 0,1,2.
      for (int i = 0; i < 3; i++) begin
         chk("alloc_tag_pre", {29'd0, alloc_tag}, i);
         alloc_valid = 1'b1; alloc_dest = 4'(5 + i);
         tick();
      end
      alloc_valid = 1'b0;
      chk("count_after_3", {28'd0, count}, 32'd3);
      chk("empty_after_3", {31'd0, empty}, 32'd0);
      chk("alloc_tag_after_3", {29'd0, alloc_tag}, 32'd3);

      // Out-of-order completion: tag1 first, then tag0.
      cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h0022;
      tick();
      cdb_valid = 1'b0;
      rd_tag = 3'd1;
      #1;
      chk("rd_ready_tag1", {31'd0, rd_ready}, 32'd1);
      chk("rd_data_tag1", {16'd0, rd_data}, 32'h22);
      rd_tag = 3'd0;
      #1;
      chk("rd_ready_tag0_pending", {31'd0, rd_ready}, 32'd0);
      tick();
      chk("no_commit_before_head", {31'd0, commit_valid}, 32'd0);
      push(3'd0, 4'd5, 16'h0011);
      push(3'd1, 4'd6, 16'h0022);
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h0011;
      tick();
      cdb_valid = 1'b0;
      chk("commit_not_yet_M", {31'd0, commit_valid}, 32'd0);
      tick();
      chk("commit0_valid", {31'd0, commit_valid}, 32'd1);
      chk("commit0_tag", {29'd0, commit_tag}, 32'd0);
      chk("count_after_c0", {28'd0, count}, 32'd2);
      tick();
      chk("commit1_valid", {31'd0, commit_valid}, 32'd1);
      chk("commit1_tag", {29'd0, commit_tag}, 32'd1);
      tick();
      chk("commit_idle", {31'd0, commit_valid}, 32'd0);
      chk("count_after_c1", {28'd0, count}, 32'd1);

      // Drain tag 2.
      push(3'd2, 4'd7, 16'h0033);
      cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h0033;
      tick();
      cdb_valid = 1'b0;
      tick();
      tick();
      chk("count_drained", {28'd0, count}, 32'd0);

      // Flush with four entries (tags 3..6), head completed the cycle before.
      for (int i = 0; i < 4; i++) begin
         alloc_valid = 1'b1; alloc_dest = 4'(1 + i);
         tick();
      end
      alloc_valid = 1'b0;
      chk("count_before_flush", {28'd0, count}, 32'd4);
      cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h0BAD;
      tick();
      cdb_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_commit_valid", {31'd0, commit_valid}, 32'd0);
      chk("flush_count", {28'd0, count}, 32'd0);
      chk("flush_empty", {31'd0, empty}, 32'd1);
      chk("flush_alloc_tag", {29'd0, alloc_tag}, 32'd0);
      tick();
      chk("flush_no_late_commit", {31'd0, commit_valid}, 32'd0);

      // Fill eight entries tags 0..7, dest 8..15.
      for (int i = 0; i < 8; i++) begin
         chk("fill_alloc_tag", {29'd0, alloc_tag}, i);
         alloc_valid = 1'b1; alloc_dest = 4'(8 + i);
         tick();
      end
      chk("fill_full", {31'd0, full}, 32'd1);
      chk("fill_alloc_ready", {31'd0, alloc_ready}, 32'd0);
      chk("fill_count", {28'd0, count}, 32'd8);
      alloc_dest = 4'hF;
      tick();
      chk("ninth_ignored_count", {28'd0, count}, 32'd8);
      // Complete head while still requesting allocation.
      push(3'd0, 4'd8, 16'h00A0);
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h00A0;
      tick();
      cdb_valid = 1'b0;
      chk("full_cdb_count", {28'd0, count}, 32'd8);
      tick();
      chk("full_commit_valid", {31'd0, commit_valid}, 32'd1);
      chk("full_commit_count", {28'd0, count}, 32'd7);
      chk("full_commit_alloc_tag", {29'd0, alloc_tag}, 32'd0);
      tick();
      alloc_valid = 1'b0;
      chk("wrap_alloc_count", {28'd0, count}, 32'd8);
      chk("wrap_alloc_tag", {29'd0, alloc_tag}, 32'd1);
      // Entry 0 now holds the wrapped allocation (dest F), not done.
      rd_tag = 3'd0;
      #1;
      chk("wrap_entry_not_done", {31'd0, rd_ready}, 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush2_count", {28'd0, count}, 32'd0);

      // Stream 20 allocate/complete pairs: cycle i allocates tag i%8 and
      // completes the entry allocated one cycle earlier.
      for (int i = 0; i <= 20; i++) begin
         alloc_valid = (i < 20);
         alloc_dest  = 4'(i);
         cdb_valid   = (i >= 1);
         cdb_tag     = 3'(i - 1);
         cdb_data    = 16'(16'h1000 + i - 1);
         if (i < 20) push(3'(i), 4'(i), 16'(16'h1000 + i));
         tick();
      end
      alloc_valid = 1'b0; cdb_valid = 1'b0;
      tick();
      tick();
      chk("stream_count", {28'd0, count}, 32'd0);
      chk("stream_alloc_tag", {29'd0, alloc_tag}, 32'd4);
      chk("stream_last_tag", {29'd0, commit_tag}, 32'd3);

      // Asynchronous reset between edges with three entries pending.
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1; alloc_dest = 4'(2 + i);
         tick();
      end
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h0077;
      tick();
      cdb_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      #2;
      rst = 1'b0;
      tick();
      tick();
      chk("post_rst_no_commit", {31'd0, commit_valid}, 32'd0);
      chk("post_rst_count", {28'd0, count}, 32'd0);
      tick();

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
